tnn_feature_loader: RTL
=======================

# tnn_feature_loader

Upstream feeder for the CGP-evolved approximate TNN classifier cores (five 3-bit features `input_a`..`input_e`, 1-bit `cgp_out`). It receives one raw 8-bit wine-quality feature per handshake and quantizes it to 3 bits against programmable per-feature thresholds. It assembles five consecutive features into one sample and presents the sample to the core through a 2-entry output FIFO with valid/ready flow control.

## Interface
- `NFEAT`, 5: features per sample. Fixed to match the core's five inputs.
- `DW`, 8: raw feature width.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: raw feature valid.
- `in_ready` out 1: loader can accept a feature.
- `in_data` in DW: raw feature value, unsigned.
- `in_last` in 1: marks the final (5th) feature of a sample.
- `cfg_we` in 1: threshold write strobe.
- `cfg_addr` in 6: [5:3] feature index 0..4, [2:0] level 0..6.
- `cfg_data` in DW: threshold value.
- `out_valid` out 1: assembled sample available.
- `out_ready` in 1: core side accepts the sample.
- `out_a`..`out_e` out 3 each: quantized features 0..4, for driving `input_a`..`input_e`.
- `err_pulse` out 1: framing error strobe.

## Operation
- Threshold RAM: 5×7 registers of DW bits. Reset value is t[f][k] = 32·(k+1), i.e. 32, 64, …, 224.
- Writes are accepted in any cycle. Writes with level 7 or feature index > 4 are ignored.
- Quantization: q = count of k in 0..6 with in_data ≥ t[f][k], where f is the current feature index.
  - Result range is 0..7.
  - Thresholds are not required to be monotonic; the count rule applies regardless.
- Feature index counter `fidx` (0..4), reset to 0. On each accepted feature (in_valid & in_ready):
  - q is stored in slot `fidx`.
  - If fidx < 4 and in_last = 0: fidx increments.
  - If fidx = 4 and in_last = 1: slots 0..3 plus the current q are pushed into the FIFO as one sample, and fidx returns to 0.
  - If fidx < 4 and in_last = 1: framing error. The sample is dropped, fidx returns to 0, and `err_pulse` is high for one cycle.
  - If fidx = 4 and in_last = 0: framing error, handled the same way (drop, fidx to 0, one-cycle `err_pulse`).
- Output FIFO: 2 entries of 15 bits, with occupancy count 0..2.
  - `out_valid` = count ≠ 0. `out_a`..`out_e` show the head entry.
  - A pop occurs on out_valid & out_ready.
- `in_ready` = (count ≠ 2), evaluated from registered count only.
  - A pop in the same cycle does not raise `in_ready` in that cycle.
  - `in_ready` applies to every feature, not only the last one.
- Simultaneous push and pop with count = 1: count stays 1 and the head advances to the new sample.
- Simultaneous push and pop with count = 2 cannot happen, because `in_ready` is 0.

## Timing
- Reset values: in_ready 1, out_valid 0, out_a..out_e 0, err_pulse 0, fidx 0, FIFO empty, thresholds at their defaults.
- Latency: `out_valid` rises in the cycle after the 5th-feature handshake when the FIFO was empty.
- No combinational path exists from in_* to out_*. `in_ready` does not depend on `out_ready` in the same cycle.
- Config/data collision: a cfg write in the same cycle as a feature accept does not affect that feature. The new threshold applies from the next cycle.
- `err_pulse` is asserted in the cycle after the offending handshake.
- Asynchronous reset mid-sample discards the partial sample and FIFO contents and restores default thresholds.
- Output data holds stable while out_valid = 1 and out_ready = 0.

## Configuration
- Macro: `TNN_LOADER_ERRCNT_EN`.
- When defined:
  - Adds output port `err_cnt`, 8 bits, reset to 0.
  - The counter increments on every framing error and saturates at 255.
  - It is cleared by any cfg write to address 6'h3F; that write does not touch the thresholds.
- When undefined: the port and the counter are absent, and address 6'h3F is ignored like any other level-7 address.

## Test plan
- Default thresholds; features 0, 31, 32, 200, 255, with last on the 5th, out_ready = 1:
  - Expect out_valid one cycle later with a,b,c,d,e = 0, 0, 1, 6, 7.
- Write t[2][0] = 10 in the same cycle feature 2 = 20 is accepted:
  - That sample yields c = 0.
  - The next sample with feature 2 = 20 yields c = 1.
- out_ready held 0; stream 3 full samples:
  - The FIFO fills after 2 samples and in_ready drops to 0.
  - Raising out_ready drains samples 1 then 2 in order. in_ready returns the cycle after the first pop.
- Assert in_last on the 3rd feature:
  - err_pulse is high for one cycle and no sample is pushed.
  - The next 5 features form a valid sample.
  - With the macro defined, err_cnt = 1.
- 5th feature without in_last:
  - Error and drop. The following feature is treated as index 0.
- Assert rst_n low after 2 features and with 1 sample queued:
  - out_valid = 0, in_ready = 1, thresholds back at defaults.
  - A fresh 5-feature sample is accepted normally.

Source files
------------

// File: rtl/tnn_feature_loader.sv
// tnn_feature_loader: quantizes raw 8-bit features to 3 bits against programmable
// per-feature thresholds and packs five of them into one sample. Samples are queued
// in a 2-entry FIFO in front of the TNN core.
// Optional feature: define TNN_LOADER_ERRCNT_EN to add a saturating framing-error
// counter on port err_cnt. A cfg write to address 6'h3F clears the counter.
module tnn_feature_loader #(
    parameter int NFEAT = 5,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    input  logic          cfg_we,
    input  logic [5:0]    cfg_addr,
    input  logic [DW-1:0] cfg_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    out_a,
    output logic [2:0]    out_b,
    output logic [2:0]    out_c,
    output logic [2:0]    out_d,
    output logic [2:0]    out_e,
    output logic          err_pulse
`ifdef TNN_LOADER_ERRCNT_EN
    ,
    output logic [7:0]    err_cnt
`endif
);
    localparam int NLVL = 7;
    localparam int QW   = 3;
    localparam int SW   = NFEAT * QW;

    logic [DW-1:0] thr_reg [NFEAT][NLVL];
    logic [2:0]    fidx_reg;
    logic [QW-1:0] slot_reg [NFEAT-1];
    logic [SW-1:0] fifo_mem_reg [2];
    logic          wr_ptr_reg;
    logic          rd_ptr_reg;
    logic [1:0]    count_reg;
    logic          err_reg;

    logic [QW-1:0] q_next;
    logic [SW-1:0] sample;
    logic [SW-1:0] head;
    logic          accept;
    logic          at_last_idx;
    logic          push;
    logic          pop;
    logic          frame_err;

    assign in_ready    = (count_reg != 2'd2);
    assign out_valid   = (count_reg != 2'd0);
    assign accept      = in_valid & in_ready;
    assign at_last_idx = (fidx_reg == 3'(NFEAT - 1));
    assign push        = accept & at_last_idx & in_last;
    assign frame_err   = accept & (at_last_idx ^ in_last);
    assign pop         = out_valid & out_ready;
    assign err_pulse   = err_reg;

    // Threshold registers: each cell only responds to its own address, so
    // level-7 and feature>4 addresses fall through untouched.
    generate
        for (genvar gi = 0; gi < NFEAT; gi++) begin : g_feat
            for (genvar gk = 0; gk < NLVL; gk++) begin : g_lvl
                // Per-cell threshold storage with default 32*(level+1).
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)
                        thr_reg[gi][gk] <= DW'(32 * (gk + 1));
                    else if (cfg_we && cfg_addr[5:3] == 3'(gi) && cfg_addr[2:0] == 3'(gk))
                        thr_reg[gi][gk] <= cfg_data;
                end
            end
        end
    endgenerate

    // Count how many thresholds of the current feature the value reaches;
    // no monotonic ordering is assumed.
    always_comb begin
        q_next = '0;
        for (int k = 0; k < NLVL; k++) begin
            if (in_data >= thr_reg[fidx_reg][k])
                q_next = q_next + 3'd1;
        end
    end

    // Feature a sits in the top bits; the last feature goes straight from q_next.
    generate
        for (genvar gi = 0; gi < NFEAT - 1; gi++) begin : g_pack
            assign sample[SW-1-gi*QW -: QW] = slot_reg[gi];

            // Capture the quantized value into its slot when that index is accepted.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    slot_reg[gi] <= '0;
                else if (accept && fidx_reg == 3'(gi))
                    slot_reg[gi] <= q_next;
            end
        end
    endgenerate
    assign sample[QW-1:0] = q_next;

    // Feature index sequencing and framing-error strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fidx_reg <= '0;
            err_reg  <= 1'b0;
        end else begin
            err_reg <= frame_err;
            if (accept) begin
                if (in_last || at_last_idx)
                    fidx_reg <= '0;
                else
                    fidx_reg <= fidx_reg + 3'd1;
            end
        end
    end

    // Two-entry output FIFO; push while full is impossible because in_ready gates it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem_reg[0] <= '0;
            fifo_mem_reg[1] <= '0;
            wr_ptr_reg      <= 1'b0;
            rd_ptr_reg      <= 1'b0;
            count_reg       <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem_reg[wr_ptr_reg] <= sample;
                wr_ptr_reg               <= ~wr_ptr_reg;
            end
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = fifo_mem_reg[rd_ptr_reg];
    assign out_a = head[14:12];
    assign out_b = head[11:9];
    assign out_c = head[8:6];
    assign out_d = head[5:3];
    assign out_e = head[2:0];

`ifdef TNN_LOADER_ERRCNT_EN
    logic [7:0] err_cnt_reg;
    assign err_cnt = err_cnt_reg;

    // Saturating framing-error counter, cleared by a write to the reserved address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt_reg <= 8'd0;
        else if (cfg_we && cfg_addr == 6'h3F)
            err_cnt_reg <= 8'd0;
        else if (frame_err && err_cnt_reg != 8'hFF)
            err_cnt_reg <= err_cnt_reg + 8'd1;
    end
`endif

endmodule
